// File: rtl/pixel_clip_fifo.sv
// rtl/pixel_clip_fifo.sv - clips signed pixel requests to the frame and queues them for the vga_adapter
// Optional duplicate-pixel suppression is built when PIXEL_DEDUP_EN is defined.
module pixel_clip_fifo #(
    parameter int DEPTH    = 16,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int COLOUR_W = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8:0]               in_x,
    input  logic [7:0]               in_y,
    input  logic [COLOUR_W-1:0]      in_colour,
    input  logic                     out_ready,
    output logic [7:0]               x,
    output logic [6:0]               y,
    output logic [COLOUR_W-1:0]      colour,
    output logic                     plot,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              clip_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 15 + COLOUR_W;
    localparam logic [8:0]  LP_X_MAX = 9'(X_MAX);
    localparam logic [7:0]  LP_Y_MAX = 8'(Y_MAX);
    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

    logic [EW-1:0]         r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_level;
    logic [15:0]           r_clip_count;
    logic [7:0]            r_x;
    logic [6:0]            r_y;
    logic [COLOUR_W-1:0]   r_colour;
    logic                  r_plot;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_onscreen;
    logic                  w_dup;
    logic                  w_push;
    logic                  w_pop;
    logic [EW-1:0]         w_entry;
    logic [EW-1:0]         w_head;

    assign w_full   = (r_level == LP_DEPTH);
    assign w_empty  = (r_level == '0);
    assign w_accept = in_valid && !w_full;

    // Sign bit clear means non-negative, so the upper bound can be an unsigned compare.
    assign w_onscreen = !in_x[8] && (in_x <= LP_X_MAX) && !in_y[7] && (in_y <= LP_Y_MAX);
    assign w_entry    = {in_x[7:0], in_y[6:0], in_colour};

`ifdef PIXEL_DEDUP_EN
    logic [EW-1:0] r_last;
    logic          r_last_vld;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_accept && w_onscreen) begin
            r_last     <= w_entry;
            r_last_vld <= 1'b1;
        end
    end

    assign w_dup = r_last_vld && (r_last == w_entry);
`else
    assign w_dup = 1'b0;
`endif

    assign w_push = w_accept && w_onscreen && !w_dup;
    assign w_pop  = !w_empty && out_ready;
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_clip_count <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
            r_plot       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                {r_x, r_y, r_colour} <= w_head;
            end
            r_plot <= w_pop;
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
            if (w_accept && !w_onscreen && (r_clip_count != 16'hFFFF)) begin
                r_clip_count <= r_clip_count + 16'd1;
            end
        end
    end

    assign in_ready   = !w_full;
    assign x          = r_x;
    assign y          = r_y;
    assign colour     = r_colour;
    assign plot       = r_plot;
    assign level      = r_level;
    assign clip_count = r_clip_count;

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// tb/tb_pixel_clip_fifo.sv - directed self-checking bench for pixel_clip_fifo
module tb_pixel_clip_fifo;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [2:0]  in_colour = '0;
    logic        out_ready = 1'b1;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic [4:0]  level;
    logic [15:0] clip_count;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int max_level = 0;
    logic [17:0] plot_q [$];
    int          stamp_q [$];
    logic [17:0] exp_q [$];

    pixel_clip_fifo #(.DEPTH(16), .X_MAX(159), .Y_MAX(119), .COLOUR_W(3)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .out_ready(out_ready),
        .x(x), .y(y), .colour(colour), .plot(plot),
        .level(level), .clip_count(clip_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (plot) begin
            plot_q.push_back({x, y, colour});
            stamp_q.push_back(cyc);
        end
        if (int'(level) > max_level) max_level = int'(level);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [17:0] pk(input int px, input int py, input int pc);
        logic [17:0] v;
        v = {px[7:0], py[6:0], pc[2:0]};
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge, valid still high.
    task automatic push_px(input int px, input int py, input int pc);
        bit done;
        done = 0;
        in_valid  = 1'b1;
        in_x      = px[8:0];
        in_y      = py[7:0];
        in_colour = pc[2:0];
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge CLOCK_50);
            if (in_ready) done = 1;
            @(posedge CLOCK_50);
            #1;
        end
        if (!done) begin
            check("push_timeout", 0, 1);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic clear_log();
        plot_q.delete();
        stamp_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int bad;
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        // Reset state
        tick(3);
        check("rst_level", int'(level), 0);
        check("rst_clip", int'(clip_count), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_xyc", int'({x, y, colour}), 0);
        reset = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        tick(1);

        // Single pixel latency
        clear_log();
        push_px(10, 20, 5);
        idle();
        check("lat_level1", int'(level), 1);
        check("lat_plot_early", int'(plot), 0);
        tick(1);
        check("lat_plot", int'(plot), 1);
        check("lat_x", int'(x), 10);
        check("lat_y", int'(y), 20);
        check("lat_colour", int'(colour), 5);
        check("lat_level0", int'(level), 0);
        tick(1);
        check("lat_plot_one_cycle", int'(plot), 0);
        check("lat_clip", int'(clip_count), 0);
        check("lat_nplots", plot_q.size(), 1);

        // Clipping
        clear_log();
        push_px(-1, 10, 1);
        check("clip_ready_a", int'(in_ready), 1);
        push_px(160, 10, 1);
        check("clip_ready_b", int'(in_ready), 1);
        push_px(10, 120, 1);
        idle();
        tick(5);
        check("clip_nplots", plot_q.size(), 0);
        check("clip_count3", int'(clip_count), 3);
        check("clip_ready", int'(in_ready), 1);

        // Fill to full with backpressure, then drain
        clear_log();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_px(i, i + 1, i % 8);
            exp_q.push_back(pk(i, i + 1, i % 8));
        end
        idle();
        check("full_level", int'(level), 16);
        check("full_ready", int'(in_ready), 0);
        in_valid = 1'b1;
        in_x = 9'd100;
        in_y = 8'd100;
        in_colour = 3'd7;
        tick(3);
        check("full_held_level", int'(level), 16);
        check("full_no_plot", plot_q.size(), 0);
        out_ready = 1'b1;
        push_px(100, 100, 7);
        exp_q.push_back(pk(100, 100, 7));
        idle();
        tick(25);
        check("drain_nplots", plot_q.size(), 17);
        bad = 0;
        for (int i = 0; i < 17 && i < plot_q.size(); i++)
            if (plot_q[i] !== exp_q[i]) bad++;
        check("drain_order_errs", bad, 0);
        if (stamp_q.size() == 17) check("drain_contig", stamp_q[16] - stamp_q[0], 16);
        else check("drain_contig_n", stamp_q.size(), 17);
        check("drain_level", int'(level), 0);

        // Back-to-back stream including corners
        clear_log();
        max_level = 0;
        for (int i = 0; i < 100; i++) begin
            int px, py;
            px = (i == 99) ? 159 : i;
            py = (i == 99) ? 119 : i % 120;
            push_px(px, py, i % 8);
            exp_q.push_back(pk(px, py, i % 8));
        end
        idle();
        tick(5);
        check("stream_nplots", plot_q.size(), 100);
        bad = 0;
        for (int i = 0; i < 100 && i < plot_q.size(); i++)
            if (plot_q[i] !== exp_q[i]) bad++;
        check("stream_order_errs", bad, 0);
        if (plot_q.size() == 100) begin
            check("stream_first_corner", int'(plot_q[0]), int'(pk(0, 0, 0)));
            check("stream_last_corner", int'(plot_q[99]), int'(pk(159, 119, 3)));
            check("stream_contig", stamp_q[99] - stamp_q[0], 99);
        end
        check("stream_max_level", max_level, 1);
        check("stream_clip", int'(clip_count), 3);

        // Reset with queued pixels
        clear_log();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_px(30 + i, 40, 2);
        idle();
        check("flush_level5", int'(level), 5);
        reset = 1'b1;
        #1;
        check("flush_plot", int'(plot), 0);
        check("flush_level", int'(level), 0);
        check("flush_clip", int'(clip_count), 0);
        tick(2);
        reset = 1'b0;
        out_ready = 1'b1;
        tick(10);
        check("flush_nplots", plot_q.size(), 0);

        // Duplicate suppression
        clear_log();
        push_px(80, 60, 2);
        push_px(80, 60, 2);
        push_px(80, 60, 3);
        idle();
        tick(5);
`ifdef PIXEL_DEDUP_EN
        check("dedup_nplots", plot_q.size(), 2);
`else
        check("dedup_nplots", plot_q.size(), 3);
`endif
        check("dedup_clip", int'(clip_count), 0);
        if (plot_q.size() > 0)
            check("dedup_last", int'(plot_q[plot_q.size() - 1]), int'(pk(80, 60, 3)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_clip_fifo.md
Name: pixel_clip_fifo

Overview:
- Sits between a shape-drawing engine (circle/square/diamond) and the vga_adapter core.
- Accepts signed pixel requests, clips them to the 160x120 frame and buffers them in a small FIFO.
- Emits one-cycle plot strobes with registered x/y/colour, so the drawing engine may compute off-screen points (for example, centre minus offset underflow) and stall on backpressure without corrupting the frame buffer.

Parameters:
- DEPTH, 16: FIFO entries; power of two, range 2..256.
- X_MAX, 159: largest on-screen x; x in 0..X_MAX passes.
- Y_MAX, 119: largest on-screen y; y in 0..Y_MAX passes.
- COLOUR_W, 3: colour width in bits.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_x  in  9  signed x, two's complement.
- in_y  in  8  signed y, two's complement.
- in_colour  in  COLOUR_W  pixel colour.
- out_ready  in  1  downstream may take a pixel; tie high for vga_adapter.
- x  out  8  registered x to vga_adapter.
- y  out  7  registered y to vga_adapter.
- colour  out  COLOUR_W  registered colour.
- plot  out  1  one-cycle write strobe.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.
- clip_count  out  16  saturating count of discarded off-screen pixels.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - FIFO empty, level=0, clip_count=0, plot=0, x=0, y=0, colour=0.
  - in_ready=1 on the first cycle after release.
  - Reset mid-operation flushes all queued pixels; none are plotted.
- in_ready = !full. No bypass: when full, a same-cycle pop does not free a slot for a push.
- Accept = in_valid && in_ready at a rising edge.
- Clip test on accept: on-screen iff in_x >= 0, in_x <= X_MAX, in_y >= 0 and in_y <= Y_MAX, compared as signed values.
  - On-screen: write {in_x[7:0], in_y[6:0], in_colour} at the write pointer.
  - Off-screen: handshake completes, nothing is written, clip_count += 1, saturating at 65535.
- Pop = !empty && out_ready.
  - At the pop edge, x/y/colour load the head entry and plot=1 for exactly that following cycle.
  - When no pop occurs, plot=0 and x/y/colour hold their last values.
- Latency: a pixel accepted into an empty FIFO at edge N appears with plot=1 after edge N+1. Minimum 2 edges, in-to-plot.
- Throughput: one pixel per cycle sustained when out_ready=1.
- Same-cycle on-screen push and pop when non-empty: both occur and level is unchanged.
- Push of a clipped pixel with a simultaneous pop: level decrements.
- Pointers wrap modulo DEPTH. Full is level==DEPTH; empty is level==0.
- out_ready low: no pop and plot=0. Queue contents and order are preserved.
- Ordering: strict FIFO; plotted order equals accepted on-screen order.

Optional Feature:
- Macro: PIXEL_DEDUP_EN.
- Defined:
  - Keep a last-accepted register {x, y, colour, valid}, cleared by reset.
  - An on-screen request identical in x, y and colour to the last accepted on-screen pixel is acknowledged but not written; clip_count is unchanged.
  - This removes the duplicate writes produced by 8-way symmetry when the offset is 0 or the two offsets are equal.
- Not defined: every on-screen pixel is queued and plotted, duplicates included.

Test Plan:
- Reset, then push (10,20,colour 3'b101) with out_ready=1 -> plot=1 two edges later with x=10, y=20, colour=101; level returns to 0; clip_count=0.
- Push in_x=-1, then in_x=160, then in_y=120, all with valid y/x -> no plot ever; clip_count=3; in_ready stays 1.
- Hold out_ready=0 and push 16 on-screen pixels (DEPTH=16) -> level=16, in_ready=0; a 17th request is held. Raise out_ready -> 16 plots in push order on consecutive cycles, then the 17th.
- Stream 100 pixels back-to-back with out_ready=1 -> level never exceeds 1; plots are contiguous at 1/cycle; corners (0,0) and (159,119) are plotted, not clipped.
- Assert reset with 5 pixels queued -> plot=0 immediately, level=0; after release nothing from before the reset is plotted.
- With PIXEL_DEDUP_EN: push (80,60,2) twice, then (80,60,3) -> exactly 2 plots. Without the macro -> 3 plots.
